execute_stage_muldiv: RTL and testbench
=======================================

// Module: execute_stage_muldiv
// PURPOSE
//  Parametrised EX stage + EX/MEM pipeline register with an integrated iterative RV64M unit.
//  Single-cycle ALU results pass straight to MEM.
//  MUL/DIV ops run a shift-add / restoring-divide FSM and hold the front end via StallE.
//  Adds flush, downstream hold and valid tracking.
// PARAMETERS
//  XLEN    64  datapath width; word (*W) ops use the low 32 bits
//  CTRL_W  8   width of the opaque control bundle carried E->M (MemtoReg, JAL, mem size, etc.)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  FlushE        in   1       squash the instruction in E
//  HoldM         in   1       MEM stage cannot accept; freeze this stage
//  ValidE        in   1       E holds a real instruction
//  MulDivE       in   1       instruction is an M-extension op
//  WordOpE       in   1       *W variant (32-bit op, result sign-extended)
//  funct3E       in   3       M-op select: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  RegWriteEnE   in   1       register write enable
//  RdE           in   5       destination register
//  CtrlE         in   CTRL_W  pass-through control bundle
//  ALUResultE    in   XLEN    result from the existing ALU (non-M ops)
//  ReadData1E    in   XLEN    rs1 (dividend / multiplicand)
//  ReadData2E    in   XLEN    rs2 (divisor / multiplier)
//  StallE        out  1       hold IF/ID/E
//  ValidM        out  1       M register holds a real instruction
//  RegWriteEnM   out  1       registered RegWriteEnE, gated by ValidM
//  RdM           out  5       registered RdE
//  CtrlM         out  CTRL_W  registered CtrlE
//  ResultM       out  XLEN    ALU or mul/div result
// BEHAVIOUR
//  Reset: FSM=IDLE, all M-register outputs 0, StallE=0, iteration counter 0.
//  Reset mid-operation aborts the op.
//  FSM states:
//   IDLE -> BUSY on ValidE&MulDivE&~FlushE&~HoldM. Latch |ops|, signs, op and Rd.
//   IDLE -> DONE directly on the divide special cases (below).
//   BUSY: one bit per cycle for N cycles (N=XLEN, or 32 if WordOpE). Counter counts N-1..0.
//   BUSY -> DONE when the counter reaches 0.
//   DONE -> IDLE: load the M register with the result, ValidM=1.
//  StallE = (IDLE & ValidE & MulDivE & ~FlushE) | BUSY | HoldM. StallE=0 in DONE, so E advances on that edge.
//  Non-M ops: M register loads ALUResultE/Rd/Ctrl on the next edge (latency 1, no stall).
//  Full M op latency: N+2 edges from entering E to ValidM=1. StallE high for N+1 cycles.
//  While StallE is high (and HoldM=0), the M register loads a bubble: ValidM=0, RegWriteEnM=0.
//  Arithmetic:
//   MUL returns the low XLEN bits of the 2*XLEN product.
//   MULH, MULHSU and MULHU return the high XLEN bits.
//   Signed ops use magnitudes and negate the 2*XLEN product when the signs differ.
//   DIV/REM: quotient truncates toward zero; remainder takes the dividend's sign.
//   Word ops: operands are bits[31:0]; result is bits[31:0] sign-extended to XLEN.
//  Special cases (fast path IDLE->DONE, latency 2):
//   Divisor 0: quotient = all ones; remainder = dividend.
//   Signed overflow (MIN/-1): quotient = MIN; remainder = 0.
//  Priority per edge: rst > FlushE > HoldM > normal.
//   FlushE in any state: FSM->IDLE, counter cleared, M register loads a bubble.
//   HoldM: FSM, counter and M register all frozen.
//  FlushE and HoldM in the same cycle: the flush wins.
//  A new M op in E in the cycle after DONE starts a fresh IDLE->BUSY sequence; no residue is reused.
// TESTING
//  1. ADD, ALUResultE=5, ValidE=1 -> next edge ResultM=5, ValidM=1; StallE never asserts.
//  2. MUL 7 x -3 (XLEN=64) -> StallE high 65 cycles; ResultM=0xFFFF_FFFF_FFFF_FFEB, ValidM=1 after 66 edges.
//  3. MULHU 0xFFFF..FF x 2 -> ResultM=1. DIVW 0x8000_0000 / -1 -> ResultM=0xFFFF_FFFF_8000_0000 after 2 edges.
//  4. DIVU 13/0 -> ResultM=all ones. REMU 13/0 -> ResultM=13. Both on the fast path, StallE high 1 cycle.
//  5. REM -7/2 -> ResultM=-1. FlushE at BUSY cycle 10 -> next cycle IDLE, StallE=0, ValidM stays 0.
//  6. HoldM high 3 cycles during BUSY -> counter frozen; total latency +3.
//     Assert rst mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/execute_stage_muldiv.sv
// execute_stage_muldiv
// EX stage plus the EX/MEM pipeline register, with an iterative RV64M unit.
// Non-M instructions pass ALUResultE straight into the M register. M-extension ops
// use a shift-add multiplier or a restoring divider that handles one bit per cycle,
// and hold the front end through StallE until the result is ready.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   FlushE            squash the instruction in E (aborts a running mul/div)
//   HoldM             MEM cannot accept; freezes FSM, counter and M register
//   ValidE, MulDivE   E holds a real instruction / it is an M-extension op
//   WordOpE           *W variant: 32-bit operands, result sign-extended
//   funct3E           0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   RegWriteEnE, RdE, CtrlE   carried into the M register
//   ALUResultE        result for non-M ops
//   ReadData1E/2E     rs1 / rs2
//   StallE            hold IF/ID/E
//   ValidM, RegWriteEnM, RdM, CtrlM, ResultM   EX/MEM register outputs
//
// state | meaning
// IDLE  | no M op in flight; M register follows E (or a bubble when an M op starts)
// BUSY  | one multiply/divide bit per cycle, counter counts N-1 down to 0
// DONE  | result ready; the M register loads it on the next edge
module execute_stage_muldiv #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              FlushE,
    input  logic              HoldM,
    input  logic              ValidE,
    input  logic              MulDivE,
    input  logic              WordOpE,
    input  logic [2:0]        funct3E,
    input  logic              RegWriteEnE,
    input  logic [4:0]        RdE,
    input  logic [CTRL_W-1:0] CtrlE,
    input  logic [XLEN-1:0]   ALUResultE,
    input  logic [XLEN-1:0]   ReadData1E,
    input  logic [XLEN-1:0]   ReadData2E,
    output logic              StallE,
    output logic              ValidM,
    output logic              RegWriteEnM,
    output logic [4:0]        RdM,
    output logic [CTRL_W-1:0] CtrlM,
    output logic [XLEN-1:0]   ResultM
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic                is_div;
    logic                is_word;
    logic                hi_sel;      // mul: high half wanted; div: remainder wanted
    logic                neg_res;
    logic                spec_hit;
    logic [XLEN-1:0]     spec_res;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     divisor;
    logic                rwe_q;
    logic [4:0]          rd_q;
    logic [CTRL_W-1:0]   ctrl_q;

    // ---------------- operand decode in E ----------------
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [31:0]       a_lo_neg, b_lo_neg;
    logic [XLEN-1:0]   a_mag, b_mag, dividend_w;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   spec_val;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3E)
            3'd0, 3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'd2:                   a_signed = 1'b1;
            default:                ;
        endcase
        a_neg    = a_signed & (WordOpE ? ReadData1E[31] : ReadData1E[XLEN-1]);
        b_neg    = b_signed & (WordOpE ? ReadData2E[31] : ReadData2E[XLEN-1]);
        // 32-bit negation kept in its own 32-bit variables so it is not widened.
        a_lo_neg = -ReadData1E[31:0];
        b_lo_neg = -ReadData2E[31:0];
        if (WordOpE) begin
            a_mag = {{(XLEN-32){1'b0}}, (a_neg ? a_lo_neg : ReadData1E[31:0])};
            b_mag = {{(XLEN-32){1'b0}}, (b_neg ? b_lo_neg : ReadData2E[31:0])};
        end else begin
            a_mag = a_neg ? -ReadData1E : ReadData1E;
            b_mag = b_neg ? -ReadData2E : ReadData2E;
        end

        dividend_w = WordOpE ? {{(XLEN-32){ReadData1E[31]}}, ReadData1E[31:0]} : ReadData1E;
        div_zero   = funct3E[2] & (WordOpE ? (ReadData2E[31:0] == 32'd0) : (ReadData2E == '0));
        div_ovf    = funct3E[2] & ~funct3E[0] &
                     (WordOpE ? ((ReadData1E[31:0] == 32'h8000_0000) && (ReadData2E[31:0] == 32'hFFFF_FFFF))
                              : ((ReadData1E == {1'b1, {(XLEN-1){1'b0}}}) && (ReadData2E == '1)));
        // On overflow the quotient is MIN, which is exactly the (sign-extended) dividend.
        if (funct3E[1])
            spec_val = div_zero ? dividend_w : '0;
        else
            spec_val = div_zero ? '1 : dividend_w;
    end

    // ---------------- iteration step ----------------
    logic [2*XLEN-1:0] prod_nx;
    logic [XLEN:0]     rem_sh, rem_sub;
    logic              rem_ge;

    always_comb begin
        prod_nx = mplier[0] ? (prod + mcand) : prod;
        rem_sh  = {rem, quo[XLEN-1]};
        rem_sub = rem_sh - {1'b0, divisor};
        rem_ge  = ~rem_sub[XLEN];
    end

    // ---------------- result formation ----------------
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res, div_mag, div_s, div_res, final_res;

    always_comb begin
        prod_s  = neg_res ? -prod : prod;
        if (is_word)
            mul_res = hi_sel ? {{(XLEN-32){prod_s[63]}}, prod_s[63:32]}
                             : {{(XLEN-32){prod_s[31]}}, prod_s[31:0]};
        else
            mul_res = hi_sel ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        div_mag = hi_sel ? rem : quo;
        div_s   = neg_res ? -div_mag : div_mag;
        div_res = is_word ? {{(XLEN-32){div_s[31]}}, div_s[31:0]} : div_s;
        if (spec_hit)
            final_res = spec_res;
        else
            final_res = is_div ? div_res : mul_res;
    end

    assign StallE = ((state == S_IDLE) & ValidE & MulDivE & ~FlushE) | (state == S_BUSY) | HoldM;

    // ---------------- FSM, datapath and EX/MEM register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            is_word     <= 1'b0;
            hi_sel      <= 1'b0;
            neg_res     <= 1'b0;
            spec_hit    <= 1'b0;
            spec_res    <= '0;
            mcand       <= '0;
            mplier      <= '0;
            prod        <= '0;
            quo         <= '0;
            rem         <= '0;
            divisor     <= '0;
            rwe_q       <= 1'b0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            ValidM      <= 1'b0;
            RegWriteEnM <= 1'b0;
            RdM         <= '0;
            CtrlM       <= '0;
            ResultM     <= '0;
        end else if (FlushE) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ValidM      <= 1'b0;
            RegWriteEnM <= 1'b0;
        end else if (!HoldM) begin
            case (state)
                S_IDLE: begin
                    if (ValidE && MulDivE) begin
                        is_div   <= funct3E[2];
                        is_word  <= WordOpE;
                        hi_sel   <= funct3E[2] ? funct3E[1] : (funct3E != 3'd0);
                        neg_res  <= (funct3E[2] && funct3E[1]) ? a_neg : (a_neg ^ b_neg);
                        rwe_q    <= RegWriteEnE;
                        rd_q     <= RdE;
                        ctrl_q   <= CtrlE;
                        mcand    <= {{XLEN{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        prod     <= '0;
                        // Left-align the dividend so the top bit shifts out first
                        // regardless of operand width.
                        quo      <= WordOpE ? (a_mag << (XLEN-32)) : a_mag;
                        rem      <= '0;
                        divisor  <= b_mag;
                        spec_hit <= div_zero | div_ovf;
                        spec_res <= spec_val;
                        if (div_zero || div_ovf) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                            cnt   <= WordOpE ? CW'(31) : CW'(XLEN-1);
                        end
                        ValidM      <= 1'b0;
                        RegWriteEnM <= 1'b0;
                    end else begin
                        ValidM      <= ValidE;
                        RegWriteEnM <= ValidE & RegWriteEnE;
                        RdM         <= RdE;
                        CtrlM       <= CtrlE;
                        ResultM     <= ALUResultE;
                    end
                end
                S_BUSY: begin
                    if (is_div) begin
                        rem <= rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], rem_ge};
                    end else begin
                        prod   <= prod_nx;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    if (cnt == '0)
                        state <= S_DONE;
                    else
                        cnt <= cnt - CW'(1);
                    ValidM      <= 1'b0;
                    RegWriteEnM <= 1'b0;
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    ValidM      <= 1'b1;
                    RegWriteEnM <= rwe_q;
                    RdM         <= rd_q;
                    CtrlM       <= ctrl_q;
                    ResultM     <= final_res;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage_muldiv.sv
module tb_execute_stage_muldiv;
    localparam int XLEN   = 64;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              FlushE, HoldM, ValidE, MulDivE, WordOpE;
    logic [2:0]        funct3E;
    logic              RegWriteEnE;
    logic [4:0]        RdE;
    logic [CTRL_W-1:0] CtrlE;
    logic [XLEN-1:0]   ALUResultE, ReadData1E, ReadData2E;
    logic              StallE, ValidM, RegWriteEnM;
    logic [4:0]        RdM;
    logic [CTRL_W-1:0] CtrlM;
    logic [XLEN-1:0]   ResultM;

    int n_pass  = 0;
    int n_total = 0;
    int edges, stalls;

    execute_stage_muldiv #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .FlushE(FlushE), .HoldM(HoldM), .ValidE(ValidE),
        .MulDivE(MulDivE), .WordOpE(WordOpE), .funct3E(funct3E),
        .RegWriteEnE(RegWriteEnE), .RdE(RdE), .CtrlE(CtrlE), .ALUResultE(ALUResultE),
        .ReadData1E(ReadData1E), .ReadData2E(ReadData2E), .StallE(StallE),
        .ValidM(ValidM), .RegWriteEnM(RegWriteEnM), .RdM(RdM), .CtrlM(CtrlM),
        .ResultM(ResultM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle, then present the op and hold it until ValidM rises.
    task automatic run_op(input logic md, input logic w, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] alu,
                          input logic [4:0] rd, input logic [7:0] ctrl,
                          output int n_edges, output int n_stalls);
        ValidE = 1'b0; MulDivE = 1'b0;
        step();
        ValidE = 1'b1; MulDivE = md; WordOpE = w; funct3E = f3;
        ReadData1E = a; ReadData2E = b; ALUResultE = alu;
        RdE = rd; CtrlE = ctrl; RegWriteEnE = 1'b1;
        n_edges = 0; n_stalls = 0;
        #1;
        while (!ValidM && n_edges < 200) begin
            if (StallE) n_stalls++;
            step();
            n_edges++;
        end
        ValidE = 1'b0; MulDivE = 1'b0;
    endtask

    initial begin
        rst = 1'b1; FlushE = 0; HoldM = 0; ValidE = 0; MulDivE = 0; WordOpE = 0;
        funct3E = 0; RegWriteEnE = 0; RdE = 0; CtrlE = 0;
        ALUResultE = 0; ReadData1E = 0; ReadData2E = 0;
        #3;
        check("rst_validm", {63'd0, ValidM}, 64'd0);
        check("rst_resultm", ResultM, 64'd0);
        check("rst_stalle", {63'd0, StallE}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // non-M op: latency 1, no stall
        run_op(0, 0, 3'd0, 64'd0, 64'd0, 64'd5, 5'd3, 8'hA5, edges, stalls);
        check("add_edges", 64'(edges), 64'd1);
        check("add_stalls", 64'(stalls), 64'd0);
        check("add_result", ResultM, 64'd5);
        check("add_validm", {63'd0, ValidM}, 64'd1);
        check("add_rdm", {59'd0, RdM}, 64'd3);
        check("add_ctrlm", {56'd0, CtrlM}, 64'hA5);
        check("add_rwe", {63'd0, RegWriteEnM}, 64'd1);

        // HoldM freezes the M register; flush beats hold
        HoldM = 1; ValidE = 1; MulDivE = 0; ALUResultE = 64'd9;
        #1;
        check("hold_stalle", {63'd0, StallE}, 64'd1);
        step();
        check("hold_result", ResultM, 64'd5);
        check("hold_validm", {63'd0, ValidM}, 64'd1);
        FlushE = 1;
        step();
        check("flush_hold_validm", {63'd0, ValidM}, 64'd0);
        FlushE = 0; HoldM = 0; ValidE = 0;

        // MUL 7 x -3
        run_op(1, 0, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 5'd4, 8'h11, edges, stalls);
        check("mul_edges", 64'(edges), 64'd66);
        check("mul_stalls", 64'(stalls), 64'd65);
        check("mul_result", ResultM, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul_rdm", {59'd0, RdM}, 64'd4);

        // MULHU all-ones x 2
        run_op(1, 0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 5'd5, 8'h00, edges, stalls);
        check("mulhu_result", ResultM, 64'd1);
        // MULHSU -1 x 2 (rs2 unsigned)
        run_op(1, 0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 5'd5, 8'h00, edges, stalls);
        check("mulhsu_result", ResultM, 64'hFFFF_FFFF_FFFF_FFFF);
        // MULW 0x7FFFFFFF x 2
        run_op(1, 1, 3'd0, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'd0, 5'd5, 8'h00, edges, stalls);
        check("mulw_edges", 64'(edges), 64'd34);
        check("mulw_result", ResultM, 64'hFFFF_FFFF_FFFF_FFFE);

        // DIVW overflow fast path
        run_op(1, 1, 3'd4, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd6, 8'h00, edges, stalls);
        check("divw_ovf_edges", 64'(edges), 64'd2);
        check("divw_ovf_stalls", 64'(stalls), 64'd1);
        check("divw_ovf_result", ResultM, 64'hFFFF_FFFF_8000_0000);

        // divide by zero fast path
        run_op(1, 0, 3'd5, 64'd13, 64'd0, 64'd0, 5'd7, 8'h00, edges, stalls);
        check("divu0_edges", 64'(edges), 64'd2);
        check("divu0_stalls", 64'(stalls), 64'd1);
        check("divu0_result", ResultM, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(1, 0, 3'd7, 64'd13, 64'd0, 64'd0, 5'd7, 8'h00, edges, stalls);
        check("remu0_result", ResultM, 64'd13);

        // signed divide / remainder
        run_op(1, 0, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 5'd8, 8'h00, edges, stalls);
        check("rem_edges", 64'(edges), 64'd66);
        check("rem_result", ResultM, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(1, 0, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 5'd8, 8'h00, edges, stalls);
        check("div_result", ResultM, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1, 0, 3'd5, 64'd100, 64'd7, 64'd0, 5'd8, 8'h00, edges, stalls);
        check("divu_result", ResultM, 64'd14);

        // flush at BUSY cycle 10
        step();
        ValidE = 1; MulDivE = 1; WordOpE = 0; funct3E = 3'd0;
        ReadData1E = 64'd7; ReadData2E = 64'd9;
        for (int i = 0; i < 10; i++) step();
        FlushE = 1; ValidE = 0; MulDivE = 0;
        step();
        FlushE = 0;
        #1;
        check("flush_stalle", {63'd0, StallE}, 64'd0);
        check("flush_validm", {63'd0, ValidM}, 64'd0);
        for (int i = 0; i < 3; i++) step();
        check("flush_validm_later", {63'd0, ValidM}, 64'd0);
        check("flush_stalle_later", {63'd0, StallE}, 64'd0);

        // fresh op after flush uses no leftover state
        run_op(1, 0, 3'd0, 64'd6, 64'd7, 64'd0, 5'd9, 8'h00, edges, stalls);
        check("post_flush_edges", 64'(edges), 64'd66);
        check("post_flush_result", ResultM, 64'd42);

        // HoldM for 3 cycles during BUSY
        step();
        ValidE = 1; MulDivE = 1; WordOpE = 0; funct3E = 3'd0;
        ReadData1E = 64'd7; ReadData2E = 64'hFFFF_FFFF_FFFF_FFFD; RdE = 5'd10;
        edges = 0;
        for (int i = 0; i < 5; i++) begin step(); edges++; end
        HoldM = 1;
        for (int i = 0; i < 3; i++) begin step(); edges++; end
        check("hold_busy_validm", {63'd0, ValidM}, 64'd0);
        HoldM = 0;
        #1;
        while (!ValidM && edges < 200) begin step(); edges++; end
        ValidE = 0; MulDivE = 0;
        check("hold_busy_edges", 64'(edges), 64'd69);
        check("hold_busy_result", ResultM, 64'hFFFF_FFFF_FFFF_FFEB);
        check("hold_busy_rdm", {59'd0, RdM}, 64'd10);

        // reset mid-BUSY
        step();
        ValidE = 1; MulDivE = 1; funct3E = 3'd0; ReadData1E = 64'd3; ReadData2E = 64'd3;
        for (int i = 0; i < 20; i++) step();
        #2;
        rst = 1; ValidE = 0; MulDivE = 0;
        #1;
        check("rst_busy_result", ResultM, 64'd0);
        check("rst_busy_validm", {63'd0, ValidM}, 64'd0);
        check("rst_busy_rdm", {59'd0, RdM}, 64'd0);
        check("rst_busy_stalle", {63'd0, StallE}, 64'd0);
        @(negedge clk);
        rst = 0;
        run_op(0, 0, 3'd0, 64'd0, 64'd0, 64'h1234, 5'd2, 8'h5A, edges, stalls);
        check("post_rst_result", ResultM, 64'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
